// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and flag record shared by decode and the ALU
package alu_pkg;

    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_XOR  = 5'd1;
    localparam logic [4:0] OP_OR   = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3;
    localparam logic [4:0] OP_ADD  = 5'd4;
    localparam logic [4:0] OP_SUB  = 5'd5;
    localparam logic [4:0] OP_SR   = 5'd6;
    localparam logic [4:0] OP_SL   = 5'd7;
    localparam logic [4:0] OP_RR   = 5'd8;
    localparam logic [4:0] OP_RL   = 5'd9;
    localparam logic [4:0] OP_DEC  = 5'd10;
    localparam logic [4:0] OP_INC  = 5'd11;
    localparam logic [4:0] OP_NOT  = 5'd12;
    localparam logic [4:0] OP_LD   = 5'd13;
    localparam logic [4:0] OP_ADC  = 5'd14;
    localparam logic [4:0] OP_SBC  = 5'd15;
    localparam logic [4:0] OP_CMP  = 5'd16;
    localparam logic [4:0] OP_MULU = 5'd17;
    localparam logic [4:0] OP_DIVU = 5'd18;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ITER = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    typedef struct packed {
        logic zero;
        logic ls_z;
        logic gr_z;
        logic carry;
        logic ovf;
        logic div0;
    } flags_t;

    // Sign/zero flags derive from the result; carry/ovf/div0 come from the op itself
    function automatic flags_t mk_flags(input logic zero, input logic msb, input logic carry,
                                        input logic ovf, input logic div0);
        return {zero, msb, !msb && !zero, carry, ovf, div0};
    endfunction

endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if: request/result bundle between the control unit and the multi-cycle ALU
interface alu_mc_if #(
    parameter int DATA_WIDTH = 8,
    parameter int OP_WIDTH   = 5
);
    logic                  start;
    logic [OP_WIDTH-1:0]   op;
    logic [DATA_WIDTH-1:0] in1_acc;
    logic [DATA_WIDTH-1:0] in2_reg;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] data_out;
    logic [DATA_WIDTH-1:0] data_hi;
    logic                  zero_f;
    logic                  ls_z_f;
    logic                  gr_z_f;
    logic                  carry_f;
    logic                  ovf_f;
    logic                  div0_f;

    modport master (
        output start, op, in1_acc, in2_reg,
        input  busy, done, data_out, data_hi, zero_f, ls_z_f, gr_z_f, carry_f, ovf_f, div0_f
    );

    modport slave (
        input  start, op, in1_acc, in2_reg,
        output busy, done, data_out, data_hi, zero_f, ls_z_f, gr_z_f, carry_f, ovf_f, div0_f
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle shift-add multiplier / restoring divider
module alu_muldiv_iter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  div_in,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  step,
    output logic                  last,
    output logic                  div_mode,
    output logic [DATA_WIDTH-1:0] lo_nxt,
    output logic [DATA_WIDTH-1:0] hi_nxt
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  hi, lo, bq;
    logic [CW-1:0] cnt;
    logic          div_q;
    logic [W:0]    msum, shifted, diff;

    // Next partial product / partial remainder; exposed so the final step lands straight in the outputs
    always_comb begin
        msum    = {1'b0, hi} + (lo[0] ? {1'b0, bq} : '0);
        shifted = {hi, lo[W-1]};
        diff    = shifted - {1'b0, bq};
        hi_nxt  = div_q ? (diff[W] ? shifted[W-1:0] : diff[W-1:0]) : msum[W:1];
        lo_nxt  = div_q ? {lo[W-2:0], !diff[W]} : {msum[0], lo[W-1:1]};
    end

    assign last     = cnt == CW'(1);
    assign div_mode = div_q;

    // Load operands on accept, then shift one bit per step until the counter runs out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi    <= '0;
            lo    <= '0;
            bq    <= '0;
            cnt   <= '0;
            div_q <= 1'b0;
        end else if (load) begin
            hi    <= '0;
            lo    <= a;
            bq    <= b;
            cnt   <= CW'(W);
            div_q <= div_in;
        end else if (step && cnt != '0) begin
            hi  <= hi_nxt;
            lo  <= lo_nxt;
            cnt <= cnt - CW'(1);
        end
    end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle accumulator ALU with registered results, flags and start/done handshake
module alu_mc
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OP_WIDTH   = 5,
    parameter bit MULDIV_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_mc_if.slave    bus
);
    localparam int W = DATA_WIDTH;

    state_t       state;
    logic [W-1:0] a, b, bop, res, fres, hi_single, out_q, hi_q, md_lo, md_hi;
    logic [W:0]   add_r, sub_r;
    logic         cin, c, v, is_add, is_sub, is_mul, is_div, dz, go_iter, md_last, md_div;
    flags_t       fl_q, fl_single, fl_md;

    assign a       = bus.in1_acc;
    assign b       = bus.in2_reg;
    assign is_mul  = MULDIV_EN && bus.op == OP_MULU;
    assign is_div  = MULDIV_EN && bus.op == OP_DIVU;
    assign dz      = is_div && b == '0;
    assign go_iter = (is_mul || is_div) && !dz;
    assign is_add  = bus.op == OP_ADD || bus.op == OP_ADC || bus.op == OP_INC;
    assign is_sub  = bus.op == OP_SUB || bus.op == OP_SBC || bus.op == OP_CMP || bus.op == OP_DEC;
    assign bop     = (bus.op == OP_INC || bus.op == OP_DEC) ? W'(1) : b;
    assign cin     = (bus.op == OP_ADC || bus.op == OP_SBC) && fl_q.carry;
    assign add_r   = {1'b0, a} + {1'b0, bop} + (W+1)'(cin);
    assign sub_r   = {1'b0, a} - {1'b0, bop} - (W+1)'(cin);

    // Single-cycle result and carry; unknown opcodes (and disabled MULU/DIVU) pass A with carry 0
    always_comb begin
        res = a;
        c   = 1'b0;
        case (bus.op)
            OP_XOR:                 res = a ^ b;
            OP_OR:                  res = a | b;
            OP_AND:                 res = a & b;
            OP_ADD, OP_ADC, OP_INC: {c, res} = add_r;
            OP_SUB, OP_SBC, OP_DEC: {c, res} = sub_r;
            OP_CMP:                 c = sub_r[W];
            OP_SR:                  {res, c} = {a[W-1], a};
            OP_SL:                  {c, res} = {a, 1'b0};
            OP_RR:                  {res, c} = {a[0], a};
            OP_RL:                  {c, res} = {a, a[W-1]};
            OP_NOT:                 res = ~a;
            OP_LD:                  res = b;
            default:                ;
        endcase
        if (dz) res = '1;
    end

    // Signed overflow: like-signed operands for add, unlike-signed for subtract, result sign flipped
    assign v = is_add ? (a[W-1] == bop[W-1] && add_r[W-1] != a[W-1]) :
               is_sub ? (a[W-1] != bop[W-1] && sub_r[W-1] != a[W-1]) : 1'b0;

    assign fres      = bus.op == OP_CMP ? sub_r[W-1:0] : res;
    assign hi_single = dz ? a : '0;
    assign fl_single = mk_flags(fres == '0, fres[W-1], c, v, dz);
    assign fl_md     = mk_flags(md_lo == '0, md_lo[W-1], !md_div && md_hi != '0, 1'b0, 1'b0);

    alu_muldiv_iter #(.DATA_WIDTH(W)) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == ST_IDLE && bus.start && go_iter),
        .div_in   (is_div),
        .a        (a),
        .b        (b),
        .step     (state == ST_ITER),
        .last     (md_last),
        .div_mode (md_div),
        .lo_nxt   (md_lo),
        .hi_nxt   (md_hi)
    );

    // Control FSM; results and flags are written only on the transition into DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            out_q <= '0;
            hi_q  <= '0;
            fl_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: if (bus.start) begin
                    if (go_iter) state <= ST_ITER;
                    else begin
                        state <= ST_DONE;
                        out_q <= res;
                        hi_q  <= hi_single;
                        fl_q  <= fl_single;
                    end
                end
                ST_ITER: if (md_last) begin
                    state <= ST_DONE;
                    out_q <= md_lo;
                    hi_q  <= md_hi;
                    fl_q  <= fl_md;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy     = state == ST_ITER;
    assign bus.done     = state == ST_DONE;
    assign bus.data_out = out_q;
    assign bus.data_hi  = hi_q;
    assign bus.zero_f   = fl_q.zero;
    assign bus.ls_z_f   = fl_q.ls_z;
    assign bus.gr_z_f   = fl_q.gr_z;
    assign bus.carry_f  = fl_q.carry;
    assign bus.ovf_f    = fl_q.ovf;
    assign bus.div0_f   = fl_q.div0;
endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised arithmetic/logic unit for the accumulator datapath. It is the successor to the single-cycle combinational ALU. It adds the following:
- registered results and a start/done handshake;
- carry and overflow flags, with carry-chained ADC/SBC;
- a flags-only compare;
- iterative unsigned multiply and divide.

It sits between the accumulator/register-file read ports and the accumulator write-back, driven by the control unit.

## Interface
- `DATA_WIDTH`, 8: operand/result width, ≥4.
- `OP_WIDTH`, 5: opcode width; must hold all `alu_pkg` codes.
- `MULDIV_EN`, 1: 0 removes MULU/DIVU; they then act as undefined ops.

Ports (clock and reset first):
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  operation request; accepted only when `busy`=0.
- `op`  in  OP_WIDTH  opcode, sampled on accept.
- `in1_acc`  in  DATA_WIDTH  operand A (accumulator), sampled on accept, signed view for flags.
- `in2_reg`  in  DATA_WIDTH  operand B (register/immediate), sampled on accept.
- `busy`  out  1  high from the cycle after accept until `done`.
- `done`  out  1  one-cycle pulse when result/flags are valid.
- `data_out`  out  DATA_WIDTH  result (low half / quotient).
- `data_hi`  out  DATA_WIDTH  MULU high half / DIVU remainder; 0 for other ops.
- `zero_f`, `ls_z_f`, `gr_z_f`, `carry_f`, `ovf_f`, `div0_f`  out  1 each  registered flags.

## Operation
- **FSM states:**
  - `IDLE`: accepts `start`.
  - `ITER`: MULU/DIVU only.
  - `DONE`: one cycle, pulses `done`, returns to `IDLE`.
- **Single-cycle ops** go `IDLE`→`DONE`. They are:
  - NOP (A)
  - XOR, OR, AND
  - ADD, SUB
  - SR (arithmetic >>1), SL (<<1)
  - RR, RL (rotate 1)
  - DEC, INC
  - NOT
  - LD (B)
  - ADC (A+B+C)
  - SBC (A−B−C)
  - CMP (flags of A−B, `data_out`=A)
- **MULU:** shift-add, one bit per `ITER` cycle, DATA_WIDTH cycles. Product is {`data_hi`,`data_out`}.
- **DIVU:** restoring division, DATA_WIDTH `ITER` cycles. Quotient goes to `data_out`, remainder to `data_hi`.
- **DIVU with B=0:** skips `ITER`. Outputs are quotient all-ones, remainder=A, `div0_f`=1. `div0_f`=0 for every other operation.
- **Undefined opcode:** `data_out`=A; carry_f and ovf_f cleared.
- **Flag rules:**
  - Flags are computed on `data_out` (CMP: on A−B).
  - zero_f = `data_out`==0.
  - ls_z_f = MSB.
  - gr_z_f = !MSB & !zero.
- **carry_f by op:**
  - ADD/ADC/INC: carry-out.
  - SUB/SBC/CMP/DEC: borrow (1 = borrow).
  - SR/RR: bit 0 of A.
  - SL/RL: MSB of A.
  - MULU: `data_hi`≠0.
  - All other ops: 0.
- **ovf_f:** signed overflow for ADD/ADC/SUB/SBC/CMP/INC/DEC; 0 otherwise.
- **Flag update timing:** flags and results update only on the `done` cycle and hold until the next `done`. ADC/SBC use the held carry_f.
- **Start while busy:** `start` while `busy`=1 (or in `DONE`) is ignored. No queueing.

## Timing
- **Reset:** all outputs 0, FSM=`IDLE`. Asserting mid-operation aborts immediately. `done` is never issued for the aborted op.
- **Single-cycle op latency:** accept at edge N → `done`=1, results valid in cycle N+1. `busy` stays 0.
- **Back-to-back:** `start` may be reasserted in the `done` cycle. It is ignored there and accepted in the next cycle (`IDLE`). Maximum throughput is one op per 2 cycles.
- **MULU/DIVU latency:** accept at N; `busy`=1 over cycles N+1 … N+DATA_WIDTH; `done` at N+DATA_WIDTH+1.
- **DIVU by zero:** behaves as a single-cycle op.
- **Output stability:** outputs are registered, with no combinational path from inputs.

## Structure
- **Shared package `alu_pkg`:**
  - opcode constants, one shared list used by decode and ALU;
  - FSM state typedef;
  - a flags struct {zero, ls_z, gr_z, carry, ovf, div0}.
- **Sub-module `alu_muldiv_iter`:** holds the shift-add/restoring datapath with its iteration counter (width clog2(DATA_WIDTH+1)).
- **Top level:** contains the FSM, the single-cycle ops and the flag logic.

## Test plan
- Reset, then ADD A=0x7F, B=0x01 → `done` the next cycle; `data_out`=0x80, ovf_f=1, carry_f=0, ls_z_f=1.
- ADD 0xFF+0x01, then ADC 0x00+0x00 → first op: 0x00, zero_f=1, carry_f=1. ADC: `data_out`=0x01, carry_f=0.
- CMP A=0x05, B=0x09 → `data_out`=0x05, carry_f=1 (borrow), ls_z_f=1, zero_f=0.
- MULU 0xFF×0xFF → `busy` for 8 cycles, `done` at accept+9; {hi,lo}=0xFE01, carry_f=1. A `start` pulsed mid-busy is ignored.
- DIVU 200/7 → `data_out`=28, `data_hi`=4. DIVU 5/0 → `done` at accept+1, `data_out`=0xFF, `data_hi`=5, `div0_f`=1.
- Assert `rst_n` low during the 4th MULU iteration → all outputs 0, no `done`. After release, INC 0x00 → 0x01.
